// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic light controller.
//   state_t       - controller state encoding
//   LIGHT_*       - {R,Y,G} one-hot lamp encodings
//   DEF_T_*       - default phase durations in seconds
//   main_lights_of / side_lights_of - lamp pattern for each state
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_1   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_2   = 3'd6,
    WALK        = 3'd7
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam int DEF_T_MAIN_GREEN = 8;
  localparam int DEF_T_SIDE_GREEN = 6;
  localparam int DEF_T_YELLOW     = 3;
  localparam int DEF_T_ALL_RED    = 1;
  localparam int DEF_T_WALK       = 5;

  function automatic logic [2:0] main_lights_of(state_t s);
    case (s)
      MAIN_GREEN:  return LIGHT_GREEN;
      MAIN_YELLOW: return LIGHT_YELLOW;
      default:     return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lights_of(state_t s);
    case (s)
      SIDE_GREEN:  return LIGHT_GREEN;
      SIDE_YELLOW: return LIGHT_YELLOW;
      default:     return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_req_latch.sv
// traffic_req_latch: sticky request latch.
//   clk, rst_n - clock and async active-low reset
//   set        - request seen this cycle
//   clr        - consume the request (wins over a same-cycle set)
//   q          - latched request
module traffic_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (set) begin
      q_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: main/side road intersection controller driving an
// external second-timer.
//   clk, Reset_n          - clock, async active-low reset
//   Sensor, Ped_Request   - side-road vehicle and pedestrian requests
//   Expired               - timer done level from the second-timer
//   Start_Timer, Value    - one-cycle start pulse and duration (seconds)
//   Timer_Clear           - one-cycle timer clear after reset release
//   Main_Lights, Side_Lights - {R,Y,G} one-hot lamps
//   Walk                  - pedestrian walk lamp
// Build option: TRAFFIC_PED_WALK_EN enables the pedestrian request latch and
// the WALK phase; without it Ped_Request is ignored and WALK is unreachable.
//
// state       | meaning
// INIT        | both red; issue Timer_Clear once, then start main green
// MAIN_GREEN  | main G, side R; restarts itself when nothing is waiting
// MAIN_YELLOW | main Y, side R
// ALL_RED_1   | both red before side green / walk
// SIDE_GREEN  | main R, side G
// SIDE_YELLOW | main R, side Y
// ALL_RED_2   | both red before walk / main green
// WALK        | both red, Walk lamp on
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int T_MAIN_GREEN = DEF_T_MAIN_GREEN,
  parameter int T_SIDE_GREEN = DEF_T_SIDE_GREEN,
  parameter int T_YELLOW     = DEF_T_YELLOW,
  parameter int T_ALL_RED    = DEF_T_ALL_RED,
  parameter int T_WALK       = DEF_T_WALK
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Sensor,
  input  logic       Ped_Request,
  input  logic       Expired,
  output logic       Start_Timer,
  output logic [3:0] Value,
  output logic       Timer_Clear,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk
);

  state_t     state_q, state_d;
  logic       clr_done_q, clr_done_d;
  logic       armed_q, armed_d;
  logic       expired_prev_q;
  logic       start_timer_q, start_timer_d;
  logic [3:0] value_q, value_d;
  logic       timer_clear_q, timer_clear_d;
  logic [2:0] main_lights_q, main_lights_d;
  logic [2:0] side_lights_q, side_lights_d;
  logic       walk_q, walk_d;

  logic       enter;
  logic       accept;
  logic       sensor_latched;
  logic       ped_latched;
  logic       sensor_clr;

  function automatic logic [3:0] dur_of(state_t s);
    case (s)
      MAIN_GREEN:             return 4'(T_MAIN_GREEN);
      SIDE_GREEN:             return 4'(T_SIDE_GREEN);
      MAIN_YELLOW,
      SIDE_YELLOW:            return 4'(T_YELLOW);
      ALL_RED_1, ALL_RED_2:   return 4'(T_ALL_RED);
      WALK:                   return 4'(T_WALK);
      default:                return 4'd0;
    endcase
  endfunction

  // Only a fresh rising edge counts, and only once per started timer, so a
  // level left high from the previous phase cannot skip the next one.
  assign accept = armed_q & Expired & ~expired_prev_q;

  always_comb begin
    state_d       = state_q;
    enter         = 1'b0;
    clr_done_d    = clr_done_q;
    timer_clear_d = 1'b0;
    case (state_q)
      INIT: begin
        if (!clr_done_q) begin
          timer_clear_d = 1'b1;
          clr_done_d    = 1'b1;
        end else begin
          state_d = MAIN_GREEN;
          enter   = 1'b1;
        end
      end
      MAIN_GREEN: begin
        if (accept) begin
          enter   = 1'b1;
          state_d = (sensor_latched || ped_latched) ? MAIN_YELLOW : MAIN_GREEN;
        end
      end
      MAIN_YELLOW: begin
        if (accept) begin
          enter   = 1'b1;
          state_d = ALL_RED_1;
        end
      end
      ALL_RED_1: begin
        if (accept) begin
          enter = 1'b1;
`ifdef TRAFFIC_PED_WALK_EN
          state_d = sensor_latched ? SIDE_GREEN : WALK;
`else
          state_d = sensor_latched ? SIDE_GREEN : MAIN_GREEN;
`endif
        end
      end
      SIDE_GREEN: begin
        if (accept) begin
          enter   = 1'b1;
          state_d = SIDE_YELLOW;
        end
      end
      SIDE_YELLOW: begin
        if (accept) begin
          enter   = 1'b1;
          state_d = ALL_RED_2;
        end
      end
      ALL_RED_2: begin
        if (accept) begin
          enter   = 1'b1;
          state_d = ped_latched ? WALK : MAIN_GREEN;
        end
      end
      WALK: begin
        if (accept) begin
          enter   = 1'b1;
          state_d = MAIN_GREEN;
        end
      end
      default: begin
        state_d    = INIT;
        clr_done_d = 1'b0;
      end
    endcase

    armed_d = enter ? 1'b1 : (armed_q & ~accept);

    // Outputs follow the next state so lamps and state flops change together.
    start_timer_d = enter;
    value_d       = dur_of(state_d);
    main_lights_d = main_lights_of(state_d);
    side_lights_d = side_lights_of(state_d);
`ifdef TRAFFIC_PED_WALK_EN
    walk_d        = (state_d == WALK);
`else
    walk_d        = 1'b0;
`endif
  end

  assign sensor_clr = enter && (state_d == SIDE_GREEN);

  traffic_req_latch u_sensor_latch (
    .clk   (clk),
    .rst_n (Reset_n),
    .set   (Sensor),
    .clr   (sensor_clr),
    .q     (sensor_latched)
  );

`ifdef TRAFFIC_PED_WALK_EN
  logic ped_clr;
  assign ped_clr = enter && (state_d == WALK);

  traffic_req_latch u_ped_latch (
    .clk   (clk),
    .rst_n (Reset_n),
    .set   (Ped_Request),
    .clr   (ped_clr),
    .q     (ped_latched)
  );
`else
  logic unused_ped_request;
  assign unused_ped_request = Ped_Request;
  assign ped_latched        = 1'b0;
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= INIT;
      clr_done_q     <= 1'b0;
      armed_q        <= 1'b0;
      expired_prev_q <= 1'b0;
      start_timer_q  <= 1'b0;
      value_q        <= 4'd0;
      timer_clear_q  <= 1'b0;
      main_lights_q  <= LIGHT_RED;
      side_lights_q  <= LIGHT_RED;
      walk_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_done_q     <= clr_done_d;
      armed_q        <= armed_d;
      expired_prev_q <= Expired;
      start_timer_q  <= start_timer_d;
      value_q        <= value_d;
      timer_clear_q  <= timer_clear_d;
      main_lights_q  <= main_lights_d;
      side_lights_q  <= side_lights_d;
      walk_q         <= walk_d;
    end
  end

  assign Start_Timer = start_timer_q;
  assign Value       = value_q;
  assign Timer_Clear = timer_clear_q;
  assign Main_Lights = main_lights_q;
  assign Side_Lights = side_lights_q;
  assign Walk        = walk_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: directed scenarios plus a
// randomized run against a phase-level reference model.
module tb_traffic_light_fsm;

  localparam int D_MG = 8;
  localparam int D_SG = 6;
  localparam int D_Y  = 3;
  localparam int D_AR = 1;
  localparam int D_W  = 5;

`ifdef TRAFFIC_PED_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  // Reference model phases (bench-local naming).
  localparam int PH_BOOT = 0;
  localparam int PH_MG   = 1;
  localparam int PH_MY   = 2;
  localparam int PH_R1   = 3;
  localparam int PH_SG   = 4;
  localparam int PH_SY   = 5;
  localparam int PH_R2   = 6;
  localparam int PH_WK   = 7;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Sensor = 1'b0;
  logic       Ped_Request = 1'b0;
  logic       Expired = 1'b0;
  logic       Start_Timer;
  logic [3:0] Value;
  logic       Timer_Clear;
  logic [2:0] Main_Lights;
  logic [2:0] Side_Lights;
  logic       Walk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          m_ph;
  bit          m_cleared, m_sensor, m_ped, m_armed, m_prev;
  logic [12:0] m_vec;

  traffic_light_fsm #(
    .T_MAIN_GREEN (D_MG),
    .T_SIDE_GREEN (D_SG),
    .T_YELLOW     (D_Y),
    .T_ALL_RED    (D_AR),
    .T_WALK       (D_W)
  ) u_dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .Sensor      (Sensor),
    .Ped_Request (Ped_Request),
    .Expired     (Expired),
    .Start_Timer (Start_Timer),
    .Value       (Value),
    .Timer_Clear (Timer_Clear),
    .Main_Lights (Main_Lights),
    .Side_Lights (Side_Lights),
    .Walk        (Walk)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] dut_vec();
    return {Start_Timer, Value, Timer_Clear, Main_Lights, Side_Lights, Walk};
  endfunction

  function automatic int ph_dur(int ph);
    case (ph)
      PH_MG: return D_MG;
      PH_SG: return D_SG;
      PH_MY, PH_SY: return D_Y;
      PH_R1, PH_R2: return D_AR;
      PH_WK: return D_W;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] ph_main(int ph);
    if (ph == PH_MG) return 3'b001;
    if (ph == PH_MY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] ph_side(int ph);
    if (ph == PH_SG) return 3'b001;
    if (ph == PH_SY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic int ph_after(int ph, bit s, bit p);
    case (ph)
      PH_MG: return (s || p) ? PH_MY : PH_MG;
      PH_MY: return PH_R1;
      PH_R1: return s ? PH_SG : (WALK_EN ? PH_WK : PH_MG);
      PH_SG: return PH_SY;
      PH_SY: return PH_R2;
      PH_R2: return p ? PH_WK : PH_MG;
      default: return PH_MG;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = PH_BOOT; m_cleared = 0; m_sensor = 0; m_ped = 0;
    m_armed = 0; m_prev = 0;
    m_vec = {1'b0, 4'd0, 1'b0, 3'b100, 3'b100, 1'b0};
  endtask

  task automatic model_edge();
    bit acc, ent, clr;
    int nph;
    acc = m_armed && Expired && !m_prev;
    ent = 0; clr = 0; nph = m_ph;
    if (m_ph == PH_BOOT) begin
      if (!m_cleared) begin clr = 1; m_cleared = 1; end
      else begin nph = PH_MG; ent = 1; end
    end else if (acc) begin
      nph = ph_after(m_ph, m_sensor, m_ped);
      ent = 1;
    end
    m_sensor = (ent && nph == PH_SG) ? 1'b0 : (m_sensor | Sensor);
    m_ped    = WALK_EN ? ((ent && nph == PH_WK) ? 1'b0 : (m_ped | Ped_Request)) : 1'b0;
    m_armed  = ent ? 1'b1 : (acc ? 1'b0 : m_armed);
    m_prev   = Expired;
    m_ph     = nph;
    m_vec = {ent, 4'(ph_dur(nph)), clr, ph_main(nph), ph_side(nph), (nph == PH_WK)};
  endtask

  // Advance one clock; returns at 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    if (!Reset_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 0; Sensor = 0; Ped_Request = 0; Expired = 0;
    model_reset();
    step(); step();
    Reset_n = 1;
    step(); step();
  endtask

  task automatic pulse_exp();
    Expired = 1; step(); Expired = 0;
  endtask

  task automatic test_reset();
    Reset_n = 0;
    step(); step();
    n_checks++;
    if (dut_vec() !== 13'b0_0000_0_100_100_0)
      $display("FAIL reset_values: got %b want %b", dut_vec(), 13'b0_0000_0_100_100_0);
    Reset_n = 1;
    step();
    n_checks++;
    if ({Timer_Clear, Start_Timer, Main_Lights} !== {1'b1, 1'b0, 3'b100}) begin
      n_fail++;
      $display("FAIL clear_cycle1: clr/start/main got %b want %b",
               {Timer_Clear, Start_Timer, Main_Lights}, {1'b1, 1'b0, 3'b100});
    end
    step();
    n_checks++;
    if ({Timer_Clear, Start_Timer, Value, Main_Lights, Side_Lights} !==
        {1'b0, 1'b1, 4'd8, 3'b001, 3'b100}) begin
      n_fail++;
      $display("FAIL main_green_cycle2: got clr=%b st=%b val=%0d main=%b side=%b want 0 1 8 001 100",
               Timer_Clear, Start_Timer, Value, Main_Lights, Side_Lights);
    end
  endtask

  task automatic test_restart();
    int starts;
    bit left_green;
    do_reset();
    starts = 0; left_green = 0;
    for (int k = 0; k < 3; k++) begin
      pulse_exp();
      if (Start_Timer === 1'b1 && Value === 4'd8) starts++;
      if (Main_Lights !== 3'b001) left_green = 1;
      for (int j = 0; j < 3; j++) begin
        step();
        if (Main_Lights !== 3'b001 || Start_Timer !== 1'b0) left_green = 1;
      end
    end
    n_checks++;
    if (starts != 3) begin
      n_fail++; $display("FAIL restart_count: got %0d want 3", starts);
    end
    n_checks++;
    if (left_green) begin
      n_fail++; $display("FAIL restart_main_green: got left_green=1 want 0");
    end
  endtask

  task automatic test_sensor();
    int exp_seq[6] = '{3, 1, 6, 3, 1, 8};
    int got[$];
    bit side_g;
    do_reset();
    Sensor = 1; step(); Sensor = 0;
    side_g = 0;
    for (int k = 0; k < 6; k++) begin
      pulse_exp();
      if (Start_Timer === 1'b1) got.push_back(int'(Value));
      if (Side_Lights === 3'b001) side_g = 1;
      for (int j = 0; j < 3; j++) step();
    end
    n_checks++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL sensor_start_count: got %0d want 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got[k] != exp_seq[k]) begin
          n_fail++; $display("FAIL sensor_value_%0d: got %0d want %0d", k, got[k], exp_seq[k]);
        end
      end
    end
    n_checks++;
    if (!side_g) begin
      n_fail++; $display("FAIL sensor_side_green: got side_g=0 want 1");
    end
    // latch was consumed at side green: main green simply restarts
    pulse_exp();
    n_checks++;
    if ({Start_Timer, Value, Main_Lights} !== {1'b1, 4'd8, 3'b001}) begin
      n_fail++;
      $display("FAIL sensor_latch_cleared: got st=%b val=%0d main=%b want 1 8 001",
               Start_Timer, Value, Main_Lights);
    end
  endtask

  task automatic test_hold();
    int starts;
    Reset_n = 0; Sensor = 0; Ped_Request = 0; Expired = 0;
    model_reset();
    step();
    Reset_n = 1;
    step();                 // Timer_Clear cycle
    Expired = 1;            // edge before any Start_Timer
    step();                 // main green entry
    starts = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (Start_Timer === 1'b1) starts++;
    end
    n_checks++;
    if (starts != 0) begin
      n_fail++; $display("FAIL early_edge_ignored: got %0d starts want 0", starts);
    end
    Expired = 0; step();
    Expired = 1;
    starts = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (Start_Timer === 1'b1) starts++;
      n_checks++;
      if (dut_vec() !== m_vec) begin
        n_fail++; $display("FAIL hold_model_%0d: got %b want %b", j, dut_vec(), m_vec);
      end
    end
    Expired = 0;
    n_checks++;
    if (starts != 1) begin
      n_fail++; $display("FAIL held_expired_once: got %0d transitions want 1", starts);
    end
  endtask

  task automatic test_ped();
    int got[$];
    bit walk_seen;
    do_reset();
    Ped_Request = 1; step(); Ped_Request = 0;
    walk_seen = 0;
    for (int k = 0; k < 4; k++) begin
      pulse_exp();
      if (Start_Timer === 1'b1) got.push_back(int'(Value));
      if (Walk === 1'b1) walk_seen = 1;
      for (int j = 0; j < 3; j++) begin
        step();
        if (Walk === 1'b1) walk_seen = 1;
      end
    end
    if (WALK_EN) begin
      n_checks++;
      if (got.size() != 4 || got[0] != 3 || got[1] != 1 || got[2] != 5 || got[3] != 8) begin
        n_fail++; $display("FAIL ped_walk_sequence: got %p want 3 1 5 8", got);
      end
      n_checks++;
      if (!walk_seen) begin
        n_fail++; $display("FAIL ped_walk_lamp: got 0 want 1");
      end
    end else begin
      n_checks++;
      if (got.size() != 4 || got[0] != 8 || got[1] != 8 || got[2] != 8 || got[3] != 8) begin
        n_fail++; $display("FAIL ped_ignored_sequence: got %p want 8 8 8 8", got);
      end
      n_checks++;
      if (walk_seen || Main_Lights !== 3'b001) begin
        n_fail++; $display("FAIL ped_ignored_lamps: got walk_seen=%0d main=%b want 0 001",
                           walk_seen, Main_Lights);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    do_reset();
    Sensor = 1; step(); Sensor = 0;
    reached = 0;
    for (int k = 0; k < 8 && !reached; k++) begin
      pulse_exp();
      if (Side_Lights === 3'b001) reached = 1;
      else begin step(); step(); end
    end
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL reach_side_green: got side=%b want 001", Side_Lights);
    end
    #1 Reset_n = 0;
    Expired = 1;
    #1;
    n_checks++;
    if ({Start_Timer, Main_Lights, Side_Lights, Walk, Value, Timer_Clear} !==
        {1'b0, 3'b100, 3'b100, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_mid: got st=%b main=%b side=%b walk=%b val=%0d clr=%b want 0 100 100 0 0 0",
               Start_Timer, Main_Lights, Side_Lights, Walk, Value, Timer_Clear);
    end
    step(); step();
    Reset_n = 1;
    step();
    n_checks++;
    if ({Timer_Clear, Start_Timer} !== 2'b10) begin
      n_fail++; $display("FAIL recover_clear: got clr/st=%b want 10", {Timer_Clear, Start_Timer});
    end
    step();
    n_checks++;
    if ({Start_Timer, Value, Main_Lights} !== {1'b1, 4'd8, 3'b001}) begin
      n_fail++; $display("FAIL recover_main_green: got st=%b val=%0d main=%b want 1 8 001",
                         Start_Timer, Value, Main_Lights);
    end
    for (int j = 0; j < 4; j++) begin
      step();
      n_checks++;
      if (dut_vec() !== m_vec) begin
        n_fail++; $display("FAIL no_stale_expiry_%0d: got %b want %b", j, dut_vec(), m_vec);
      end
    end
    Expired = 0;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 4000; c++) begin
      Sensor      = ($urandom_range(0, 15) == 0);
      Ped_Request = ($urandom_range(0, 15) == 0);
      Expired     = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if (dut_vec() !== m_vec) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got %b want %b", c, dut_vec(), m_vec);
        errs++;
      end
    end
    Sensor = 0; Ped_Request = 0; Expired = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_restart();
    test_sensor();
    test_hold();
    test_ped();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
